// File: rtl/spectro_frame_receiver.sv
// Deserializes the 2-lane spectrogram readout into a timestamp plus ch1/ch2 sample pairs per frame.
// Optional FRAME_CHECKSUM_EN adds frame_checksum, the mod-256 sum of all sample pairs in a frame.
module spectro_frame_receiver #(
    parameter int TIME_BITS   = 32,
    parameter int SAMPLE_BITS = 3,
    parameter int MAX_SAMPLES = 511
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             serial_in,
    input  logic                   sending_data,
    input  logic                   sl_time,
    input  logic                   sl_ch,
    output logic [TIME_BITS-1:0]   event_time,
    output logic                   time_valid,
    output logic [SAMPLE_BITS-1:0] sample_ch1,
    output logic [SAMPLE_BITS-1:0] sample_ch2,
    output logic [8:0]             sample_idx,
    output logic                   sample_valid,
    output logic                   frame_done,
    output logic                   frame_error
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [7:0]             frame_checksum
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TIME   = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_SAMPLE = 2'd3;

    localparam int CNT_W = $clog2(TIME_BITS);
    localparam logic [CNT_W-1:0] LAST_TIME_BIT   = CNT_W'(TIME_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE_BIT = CNT_W'(SAMPLE_BITS - 1);
    localparam logic [8:0]       MAX_CNT         = 9'(MAX_SAMPLES);

    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [8:0]             sample_cnt;
    // Shift registers hold only the bits already received; the incoming bit completes the word.
    logic [TIME_BITS-2:0]   time_sr;
    logic [SAMPLE_BITS-2:0] ch1_sr;
    logic [SAMPLE_BITS-2:0] ch2_sr;
    logic [TIME_BITS-1:0]   time_next;
    logic [SAMPLE_BITS-1:0] ch1_next;
    logic [SAMPLE_BITS-1:0] ch2_next;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]             sum;
`endif

    assign time_next = {time_sr, serial_in[0]};
    assign ch1_next  = {ch1_sr, serial_in[0]};
    assign ch2_next  = {ch2_sr, serial_in[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            sample_cnt   <= '0;
            time_sr      <= '0;
            ch1_sr       <= '0;
            ch2_sr       <= '0;
            event_time   <= '0;
            time_valid   <= 1'b0;
            sample_ch1   <= '0;
            sample_ch2   <= '0;
            sample_idx   <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum            <= '0;
            frame_checksum <= '0;
`endif
        end else begin
            time_valid   <= 1'b0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sending_data && sl_time) begin
                        state   <= S_TIME;
                        bit_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
                        sum     <= '0;
`endif
                    end
                end
                S_TIME: begin
                    if (!sending_data || sl_time || sl_ch) begin
                        frame_error <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        time_sr <= time_next[TIME_BITS-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_TIME_BIT) begin
                            event_time <= time_next;
                            time_valid <= 1'b1;
                            sample_cnt <= '0;
                            sample_idx <= '0;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!sending_data) begin
                        if (sample_cnt != '0) begin
                            frame_done <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                            frame_checksum <= sum;
`endif
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else if (sl_time) begin
                        frame_error <= 1'b1;
                        state       <= S_IDLE;
                    end else if (sl_ch) begin
                        bit_cnt <= '0;
                        state   <= S_SAMPLE;
                    end
                end
                default: begin // S_SAMPLE
                    if (!sending_data) begin
                        frame_error <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        ch1_sr  <= ch1_next[SAMPLE_BITS-2:0];
                        ch2_sr  <= ch2_next[SAMPLE_BITS-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_SAMPLE_BIT) begin
                            if (sample_cnt == MAX_CNT) begin
                                frame_error <= 1'b1;
                                state       <= S_IDLE;
                            end else begin
                                sample_ch1   <= ch1_next;
                                sample_ch2   <= ch2_next;
                                sample_idx   <= sample_cnt;
                                sample_valid <= 1'b1;
                                sample_cnt   <= sample_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                                sum <= sum + 8'(ch1_next) + 8'(ch2_next);
`endif
                                // A strobe on the final bit cycle chains straight into the next pair.
                                bit_cnt <= '0;
                                state   <= sl_ch ? S_SAMPLE : S_WAIT;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Scoreboard bench for spectro_frame_receiver: expected events queued at stimulus, compared per scenario.
module tb_spectro_frame_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  serial_in = 2'b00;
    logic        sending_data = 1'b0;
    logic        sl_time = 1'b0;
    logic        sl_ch = 1'b0;
    logic [31:0] event_time;
    logic        time_valid;
    logic [2:0]  sample_ch1;
    logic [2:0]  sample_ch2;
    logic [8:0]  sample_idx;
    logic        sample_valid;
    logic        frame_done;
    logic        frame_error;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  frame_checksum;
`endif

    spectro_frame_receiver #(.TIME_BITS(32), .SAMPLE_BITS(3), .MAX_SAMPLES(511)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .sending_data(sending_data),
        .sl_time(sl_time), .sl_ch(sl_ch), .event_time(event_time), .time_valid(time_valid),
        .sample_ch1(sample_ch1), .sample_ch2(sample_ch2), .sample_idx(sample_idx),
        .sample_valid(sample_valid), .frame_done(frame_done), .frame_error(frame_error)
`ifdef FRAME_CHECKSUM_EN
        , .frame_checksum(frame_checksum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_s[$], obs_s[$];
    logic [31:0] exp_t[$], obs_t[$];
    int n_done, n_err, n_overlap_total;
    logic [7:0] obs_ck;
    logic [8:0] idx;

    always @(negedge clk) begin
        if (sample_valid) obs_s.push_back({sample_idx, sample_ch1, sample_ch2});
        if (time_valid) obs_t.push_back(event_time);
        if (frame_done) begin
            n_done++;
`ifdef FRAME_CHECKSUM_EN
            obs_ck = frame_checksum;
`endif
        end
        if (frame_error) n_err++;
        if (sample_valid && time_valid) n_overlap_total++;
    end

    task automatic drive(input logic sd, input logic st, input logic sc, input logic [1:0] s);
        sending_data = sd; sl_time = st; sl_ch = sc; serial_in = s;
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        exp_s.delete(); obs_s.delete(); exp_t.delete(); obs_t.delete();
        n_done = 0; n_err = 0; obs_ck = 8'h00; idx = '0;
    endtask

    task automatic send_time(input logic [31:0] t);
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 1'b0, {1'b0, t[31-i]});
        exp_t.push_back(t);
    endtask

    task automatic send_bits(input logic [2:0] c1, input logic [2:0] c2, input logic chain);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, (i == 2) && chain, {c2[2-i], c1[2-i]});
    endtask

    task automatic send_sample(input logic [2:0] c1, input logic [2:0] c2);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        send_bits(c1, c2, 1'b0);
        exp_s.push_back({idx, c1, c2});
        idx++;
    endtask

    task automatic end_frame();
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        checks++;
        if ({event_time, time_valid, sample_ch1, sample_ch2, sample_idx, sample_valid, frame_done, frame_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: event_time=%h tv=%b ch1=%0d ch2=%0d idx=%0d sv=%b done=%b err=%b, expected all 0",
                     event_time, time_valid, sample_ch1, sample_ch2, sample_idx, sample_valid, frame_done, frame_error);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        clear_obs();
        send_time(32'hDEADBEEF);
        send_sample(3'd5, 3'd2);
        send_sample(3'd7, 3'd0);
        end_frame();
        checks++;
        if (obs_t.size() != exp_t.size()) begin errors++; $display("FAIL basic_time_count: got %0d expected %0d", obs_t.size(), exp_t.size()); end
        for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] !== exp_t[i]) begin errors++; $display("FAIL basic_time: got %h expected %h", obs_t[i], exp_t[i]); end
        end
        checks++;
        if (obs_s.size() != exp_s.size()) begin errors++; $display("FAIL basic_sample_count: got %0d expected %0d", obs_s.size(), exp_s.size()); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
            checks++;
            if (obs_s[i] !== exp_s[i]) begin errors++; $display("FAIL basic_sample[%0d]: got %h expected %h", i, obs_s[i], exp_s[i]); end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", n_done); end
        checks++;
        if (n_err != 0) begin errors++; $display("FAIL basic_error: got %0d expected 0", n_err); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_time(32'h0BADF00D);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            logic [2:0] c1, c2;
            c1 = 3'(k + 1);
            c2 = 3'(6 - k);
            send_bits(c1, c2, k < 3);
            exp_s.push_back({idx, c1, c2});
            idx++;
        end
        end_frame();
        checks++;
        if (obs_s.size() != exp_s.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_s.size(), exp_s.size()); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
            checks++;
            if (obs_s[i] !== exp_s[i]) begin errors++; $display("FAIL b2b_sample[%0d]: got %h expected %h", i, obs_s[i], exp_s[i]); end
        end
        checks++;
        if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL b2b_end: done=%0d err=%0d expected done=1 err=0", n_done, n_err); end
    endtask

    task automatic test_time_abort();
        test_reset();
        clear_obs();
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 2'b01);
        end_frame();
        checks++;
        if (n_err != 1) begin errors++; $display("FAIL abort_error: got %0d expected 1", n_err); end
        checks++;
        if (obs_t.size() != 0) begin errors++; $display("FAIL abort_time_valid: got %0d pulses expected 0", obs_t.size()); end
        checks++;
        if (event_time !== 32'h0) begin errors++; $display("FAIL abort_event_time: got %h expected 00000000", event_time); end
    endtask

    task automatic test_overflow();
        clear_obs();
        send_time(32'h00000511);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        for (int k = 0; k < 512; k++) begin
            logic [2:0] c1, c2;
            c1 = 3'(k % 8);
            c2 = 3'((k / 8) % 8);
            send_bits(c1, c2, k < 511);
            if (k < 511) begin
                exp_s.push_back({idx, c1, c2});
                idx++;
            end
        end
        end_frame();
        checks++;
        if (obs_s.size() != 511) begin errors++; $display("FAIL ovf_count: got %0d expected 511", obs_s.size()); end
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
            checks++;
            if (obs_s[i] !== exp_s[i]) begin errors++; $display("FAIL ovf_sample[%0d]: got %h expected %h", i, obs_s[i], exp_s[i]); end
        end
        checks++;
        if (n_err != 1 || n_done != 0) begin errors++; $display("FAIL ovf_end: err=%0d done=%0d expected err=1 done=0", n_err, n_done); end
        checks++;
        if (sample_idx !== 9'd510) begin errors++; $display("FAIL ovf_idx: got %0d expected 510", sample_idx); end
    endtask

    task automatic test_reset_mid_sample();
        clear_obs();
        send_time(32'hCAFEF00D);
        send_sample(3'd6, 3'd1);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b0, 2'b10);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b11);
        @(negedge clk);
        checks++;
        if ({event_time, time_valid, sample_ch1, sample_ch2, sample_idx, sample_valid, frame_done, frame_error} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: event_time=%h ch1=%0d ch2=%0d idx=%0d err=%b, expected all 0",
                     event_time, sample_ch1, sample_ch2, sample_idx, frame_error);
        end
        reset = 1'b0;
        end_frame();
        checks++;
        if (n_err != 0) begin errors++; $display("FAIL midreset_error: got %0d expected 0", n_err); end
        checks++;
        if (obs_s.size() != 1) begin errors++; $display("FAIL midreset_samples: got %0d expected 1", obs_s.size()); end
        clear_obs();
        send_time(32'h12345678);
        send_sample(3'd3, 3'd4);
        end_frame();
        checks++;
        if (obs_t.size() != 1 || obs_t[0] !== 32'h12345678) begin
            errors++; $display("FAIL midreset_next_time: got %0d pulses first=%h expected 1 pulse 12345678", obs_t.size(), event_time);
        end
        checks++;
        if (obs_s.size() != 1 || obs_s[0] !== exp_s[0]) begin
            errors++; $display("FAIL midreset_next_sample: got %0d pulses value=%0d/%0d expected 1 pulse 3/4", obs_s.size(), sample_ch1, sample_ch2);
        end
        checks++;
        if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL midreset_next_end: done=%0d err=%0d expected 1/0", n_done, n_err); end
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        clear_obs();
        send_time(32'h00000001);
        send_sample(3'd7, 3'd7);
        send_sample(3'd7, 3'd7);
        send_sample(3'd3, 3'd1);
        end_frame();
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL cksum_done: got %0d expected 1", n_done); end
        checks++;
        if (obs_ck !== 8'h20) begin errors++; $display("FAIL cksum_value: got %h expected 20", obs_ck); end
    endtask
`endif

    task automatic test_exclusive();
        checks++;
        if (n_overlap_total != 0) begin errors++; $display("FAIL valid_overlap: got %0d cycles expected 0", n_overlap_total); end
    endtask

    initial begin
        n_overlap_total = 0;
        clear_obs();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_time_abort();
        test_overflow();
        test_reset_mid_sample();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
